blink_fader: RTL and testbench

- Downstream consumer of the blink generator's `led` level and `flg` wrap pulse.
- Converts the hard on/off `led` into a PWM brightness output that ramps up and down linearly.
- Watches `flg` and raises a stall flag if the upstream counter stops wrapping.
- Sits between the blink generator and the board LED pin.

---
 rtl/blink_fader.sv | 108 ++++++++++
 tb/tb_blink_fader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/blink_fader.sv
// LED fader: turns the blink generator's on/off level into a linearly ramping PWM drive,
// and flags a stall when the upstream wrap pulse stops arriving.
module blink_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 1,
  parameter int WD_BITS  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                led_in,
  input  logic                flg_in,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          state,
  output logic                stall
);

  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] ON   = 2'd2;
  localparam logic [1:0] DOWN = 2'd3;

  localparam logic [PWM_BITS-1:0] DMAX   = '1;
  localparam logic [WD_BITS-1:0]  WMAX   = '1;
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_next;
  logic [PWM_BITS-1:0] duty_up;
  logic [PWM_BITS-1:0] duty_dn;
  logic [PWM_BITS:0]   sum_up;
  logic [1:0]          state_next;
  logic                period_end;
  logic [WD_BITS-1:0]  wd_cnt;
  logic [WD_BITS-1:0]  wd_next;

  assign period_end = (pwm_cnt == DMAX);

  // One extra bit of headroom so the step can saturate instead of wrapping.
  always_comb begin
    sum_up  = {1'b0, duty} + STEP_W;
    duty_up = (sum_up > {1'b0, DMAX}) ? DMAX : sum_up[PWM_BITS-1:0];
    duty_dn = ({1'b0, duty} < STEP_W) ? '0 : (duty - STEP_W[PWM_BITS-1:0]);
  end

  // A led_in reversal takes priority over a coincident period-end step.
  always_comb begin
    state_next = state;
    duty_next  = duty;
    case (state)
      OFF: begin
        duty_next = '0;
        if (led_in) state_next = UP;
      end
      UP: begin
        if (!led_in) begin
          state_next = DOWN;
        end else if (period_end) begin
          duty_next = duty_up;
          if (duty_up == DMAX) state_next = ON;
        end
      end
      ON: begin
        duty_next = DMAX;
        if (!led_in) state_next = DOWN;
      end
      default: begin
        if (led_in) begin
          state_next = UP;
        end else if (period_end) begin
          duty_next = duty_dn;
          if (duty_dn == '0) state_next = OFF;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      duty    <= '0;
      state   <= OFF;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      duty    <= duty_next;
      state   <= state_next;
      pwm_out <= (pwm_cnt < duty);
    end
  end

  always_comb begin
    if (flg_in)             wd_next = '0;
    else if (wd_cnt == WMAX) wd_next = WMAX;
    else                     wd_next = wd_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      stall  <= 1'b0;
    end else begin
      wd_cnt <= wd_next;
      stall  <= (wd_next == WMAX);
    end
  end

endmodule

// File: tb/tb_blink_fader.sv
// Bench for blink_fader: a STEP=4 instance for ramp/reversal/watchdog and a STEP=6
// instance for clamping, checked against hand-derived expectations via a scoreboard queue.
module tb_blink_fader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       led4 = 1'b0;
  logic       led6 = 1'b0;
  logic       flg = 1'b0;
  logic       pwm4, pwm6, stall4, stall6;
  logic [3:0] duty4, duty6;
  logic [1:0] state4, state6;

  always #5 clk = ~clk;

  blink_fader #(.PWM_BITS(4), .STEP(4), .WD_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .led_in(led4), .flg_in(flg),
    .pwm_out(pwm4), .duty(duty4), .state(state4), .stall(stall4)
  );

  blink_fader #(.PWM_BITS(4), .STEP(6), .WD_BITS(4)) dut6 (
    .clk(clk), .rst(rst), .led_in(led6), .flg_in(flg),
    .pwm_out(pwm6), .duty(duty6), .state(state6), .stall(stall6)
  );

  typedef struct {
    string name;
    int    sig;
    int    value;
  } exp_t;

  typedef struct {
    string name;
    bit    wide;
    int    cycles;
    bit    led;
    int    duty;
    int    state;
    int    pwm;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Signal codes: 0..3 = duty/state/pwm/stall of dut4, 4..7 = same for dut6.
  function automatic int probe(int sig);
    case (sig)
      0: return int'(duty4);
      1: return int'(state4);
      2: return int'(pwm4);
      3: return int'(stall4);
      4: return int'(duty6);
      5: return int'(state6);
      6: return int'(pwm6);
      7: return int'(stall6);
      default: return -1;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic push(string name, int sig, int value);
    exp_t e;
    e.name  = name;
    e.sig   = sig;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, probe(e.sig), e.value);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(string name, bit wide, int cycles, bit led, int d, int s, int p);
    vec_t v;
    v.name = name; v.wide = wide; v.cycles = cycles; v.led = led;
    v.duty = d; v.state = s; v.pwm = p;
    vt.push_back(v);
  endtask

  task automatic run_vectors(int lo, int hi);
    int base;
    for (int i = lo; i <= hi; i++) begin
      if (vt[i].wide) begin led6 = vt[i].led; led4 = 1'b0; end
      else            begin led4 = vt[i].led; led6 = 1'b0; end
      base = vt[i].wide ? 4 : 0;
      push({vt[i].name, " duty"},  base + 0, vt[i].duty);
      push({vt[i].name, " state"}, base + 1, vt[i].state);
      push({vt[i].name, " pwm"},   base + 2, vt[i].pwm);
      repeat (vt[i].cycles) tick();
      drain();
    end
  endtask

  initial begin
    int highs;

    // Edge numbers below count clk edges since reset release.
    add("up e1",     0,  1, 1,  0, 1, 0);
    add("up e15",    0, 14, 1,  0, 1, 0);
    add("up e16",    0,  1, 1,  4, 1, 0);
    add("up e47",    0, 15, 1,  8, 1, 0);
    add("up e48",    0,  1, 1, 12, 1, 0);
    add("up e63",    0, 15, 1, 12, 1, 0);
    add("on e64",    0,  1, 1, 15, 2, 0);
    add("dn e65",    0,  1, 0, 15, 3, 1);
    add("dn e79",    0, 14, 0, 15, 3, 1);
    add("dn e80",    0,  1, 0, 11, 3, 0);
    add("dn e96",    0, 16, 0,  7, 3, 0);
    add("dn e112",   0, 16, 0,  3, 3, 0);
    add("off e128",  0, 16, 0,  0, 0, 0);
    add("rev e129",  0,  1, 1,  0, 1, 0);
    add("rev e144",  0, 15, 1,  4, 1, 0);
    add("rev e160",  0, 16, 1,  8, 1, 0);
    add("rev e175",  0, 15, 1,  8, 1, 0);
    add("rev e176",  0,  1, 0,  8, 3, 0);
    add("rev e191",  0, 15, 0,  8, 3, 0);
    add("rev e192",  0,  1, 0,  4, 3, 0);
    add("rev e208",  0, 16, 0,  0, 0, 0);
    add("sat e209",  1,  1, 1,  0, 1, 0);
    add("sat e224",  1, 15, 1,  6, 1, 0);
    add("sat e240",  1, 16, 1, 12, 1, 0);
    add("sat e256",  1, 16, 1, 15, 2, 0);
    add("sat e257",  1,  1, 0, 15, 3, 1);
    add("sat e272",  1, 15, 0,  9, 3, 0);
    add("sat e288",  1, 16, 0,  3, 3, 0);
    add("sat e304",  1, 16, 0,  0, 0, 0);

    // Reset held for 3 cycles with led high and flg toggling.
    led4 = 1'b1;
    led6 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      flg = ~flg;
      push("rst pwm",   2, 0);
      push("rst duty",  0, 0);
      push("rst state", 1, 0);
      push("rst stall", 3, 0);
      push("rst state6", 5, 0);
      tick();
      drain();
    end
    flg  = 1'b0;
    led6 = 1'b0;
    rst  = 1'b1;

    run_vectors(0, 2);

    // First period after the first step: duty=4 gives 4 high cycles of 16.
    highs = 0;
    push("up e32 duty",  0, 8);
    push("up e32 state", 1, 1);
    repeat (16) begin
      tick();
      highs += int'(pwm4);
    end
    check("pwm highs duty4", highs, 4);
    drain();

    run_vectors(3, vt.size() - 1);

    // Sub-cycle led glitch between edges must not start a ramp.
    #2 led4 = 1'b1;
    #3 led4 = 1'b0;
    push("glitch state", 1, 0);
    push("glitch duty",  0, 0);
    tick();
    drain();

    // Watchdog: upstream silent since release, so stall is already up.
    led4 = 1'b1;
    push("wd idle stall", 3, 1);
    drain();
    flg = 1'b1;
    push("wd flg clears", 3, 0);
    tick();
    drain();
    flg = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      push($sformatf("wd stall k%0d", k), 3, (k >= 15) ? 1 : 0);
      tick();
      drain();
    end
    flg = 1'b1;
    push("wd second flg clears", 3, 0);
    tick();
    drain();
    flg = 1'b0;
    repeat (16) tick();
    push("wd restall", 3, 1);
    push("midramp duty", 0, 8);
    push("midramp state", 1, 1);
    drain();

    // Asynchronous reset mid-ramp, away from any clock edge.
    #2 rst = 1'b0;
    #1;
    push("async stall", 3, 0);
    push("async duty",  0, 0);
    push("async state", 1, 0);
    push("async pwm",   2, 0);
    drain();
    tick();
    #2 rst = 1'b1;
    push("rerelease state", 1, 1);
    push("rerelease duty",  0, 0);
    tick();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
